dot_vec_feeder: RTL

- Source-side companion to the streaming dot-product accumulator.
- Holds two S-element operand vectors, loaded through a simple write port.
- On start, streams the element pairs (a_i, b_i) one per accepted cycle with a valid/ready handshake, then waits for the accumulator's result.
- Captures the result and compares it against an internally computed golden dot product. Used as the operand feeder and on-chip checker in front of the dot-product unit.

---
 rtl/dot_vec_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dot_vec_feeder.sv
// Operand feeder and on-chip checker for the streaming dot-product unit.
// Streams (A[i], B[i]) pairs over valid/ready, then compares the returned result to a golden sum.

module dot_vec_feeder_elem #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we_a,
  input  logic         i_we_b,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);
  logic [W-1:0] r_a, r_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_we_a) r_a <= i_data;
      if (i_we_b) r_b <= i_data;
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
endmodule

module dot_vec_feeder #(
  parameter int S  = 9,
  parameter int W  = 8,
  parameter int RW = 16,
  localparam int IW = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [IW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  output logic          last,
  input  logic          res_valid,
  input  logic [RW-1:0] res_in,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          match
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_t;

  state_t              r_state, w_nxt_state;
  logic [IW-1:0]       r_idx, w_nxt_idx;
  logic [RW-1:0]       r_golden, w_nxt_golden;
  logic [RW-1:0]       r_result;
  logic                r_match;

  logic [S-1:0][W-1:0] w_mem_a, w_mem_b;
  logic [IW-1:0]       w_rd_idx;
  logic [W-1:0]        w_a_rd, w_b_rd;
  logic [RW-1:0]       w_prod;
  logic                w_idle_like, w_wr_ok, w_last, w_cap;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_wr_ok     = wr_en && w_idle_like && !clear;
  assign w_last      = (r_state == STREAM) && (r_idx == IW'(S-1));
  assign w_cap       = (r_state == WAIT_RES) && res_valid && !clear;

  // Addresses >= S match no element, so out-of-range writes drop naturally.
  for (genvar i = 0; i < S; i++) begin : g_elem
    dot_vec_feeder_elem #(.W(W)) u_elem (
      .clk    (clk),
      .reset  (reset),
      .i_we_a (w_wr_ok && !wr_sel && (wr_addr == IW'(i))),
      .i_we_b (w_wr_ok &&  wr_sel && (wr_addr == IW'(i))),
      .i_data (wr_data),
      .o_a    (w_mem_a[i]),
      .o_b    (w_mem_b[i])
    );
  end

  assign w_rd_idx = (r_state == STREAM) ? r_idx : '0;
  assign w_a_rd   = w_mem_a[w_rd_idx];
  assign w_b_rd   = w_mem_b[w_rd_idx];
  // Product only needed mod 2^RW, so multiply at RW bits.
  assign w_prod   = RW'(w_a_rd) * RW'(w_b_rd);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_nxt_golden = r_golden;
    if (clear) begin
      w_nxt_state  = IDLE;
      w_nxt_idx    = '0;
      w_nxt_golden = '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_nxt_state  = STREAM;
            w_nxt_idx    = '0;
            w_nxt_golden = '0;
          end
        end
        STREAM: begin
          if (out_ready) begin
            w_nxt_golden = r_golden + w_prod;
            if (w_last) begin
              w_nxt_idx   = '0;
              w_nxt_state = WAIT_RES;
            end else begin
              w_nxt_idx = r_idx + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          if (res_valid) w_nxt_state = DONE;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_golden <= '0;
      r_result <= '0;
      r_match  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_idx    <= w_nxt_idx;
      r_golden <= w_nxt_golden;
      if (w_cap) begin
        r_result <= res_in;
        r_match  <= (res_in == r_golden);
      end
    end
  end

  assign out_valid = (r_state == STREAM);
  assign last      = w_last;
  assign a_out     = w_a_rd;
  assign b_out     = w_b_rd;
  assign busy      = (r_state == STREAM) || (r_state == WAIT_RES);
  assign done      = w_cap;
  assign result    = r_result;
  assign match     = r_match;
endmodule
